// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 execute stage: icode constants, ALU
// function and condition encodings, CC bit layout and a condition helper.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3,
    ALU_MUL = 4'h4
  } alu_fn_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_e;

  // CC register layout is {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  // Highest legal condition code for cmovXX / jXX
  localparam logic [3:0] COND_MAX = 4'h6;

  // Evaluate a branch/move condition against a CC value; unknown codes give 0
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic lt;
    logic res;
    lt  = cc[CC_SF] ^ cc[CC_OF];
    res = 1'b0;
    case (fn)
      C_ALWAYS: res = 1'b1;
      C_LE:     res = lt | cc[CC_ZF];
      C_L:      res = lt;
      C_E:      res = cc[CC_ZF];
      C_NE:     res = ~cc[CC_ZF];
      C_GE:     res = ~lt;
      C_G:      res = ~lt & ~cc[CC_ZF];
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational OPq ALU: result is b op a, with ZF/SF/OF flags.
// Optional signed multiply on function 4 when Y86_EXEC_IMUL_EN is defined.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   fn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         fn_valid
);

`ifdef Y86_EXEC_IMUL_EN
  logic signed [2*W-1:0] product;
  assign product = $signed(b) * $signed(a);
`endif

  // Operation select and overflow detection
  always_comb begin
    result   = '0;
    of       = 1'b0;
    fn_valid = 1'b1;
    case (fn)
      ALU_ADD: begin
        result = b + a;
        of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (b[W-1] != a[W-1]) && (result[W-1] != b[W-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
`ifdef Y86_EXEC_IMUL_EN
      ALU_MUL: begin
        result = product[W-1:0];
        // Overflow when the upper half is not the sign extension of the lower
        of     = (product[2*W-1:W] != {W{product[W-1]}});
      end
`endif
      default: fn_valid = 1'b0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[W-1];

endmodule

// File: rtl/y86_execute_stage.sv
// Registered Y86 execute stage: computes valE and cnd, owns the CC register,
// latches halt and flags invalid instructions. One-cycle latency with a
// valid/ready handshake on both sides.
// Optional feature macro: Y86_EXEC_IMUL_EN (OPq ifun 4 = signed multiply).
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int W          = 64,
  parameter int STACK_STEP = W / 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_valE,
  output logic         out_cnd,
  output logic         out_err,
  output logic [2:0]   cc,
  output logic         halted
);

  localparam logic [W-1:0] STEP = W'(STACK_STEP);

  logic         accept;
  logic [W-1:0] alu_result;
  logic         alu_zf;
  logic         alu_sf;
  logic         alu_of;
  logic         alu_fn_valid;
  logic [W-1:0] val_e_calc;
  logic         cnd_calc;
  logic         err_calc;
  logic         cc_we;

  y86_alu #(.W(W)) u_alu (
    .fn       (ifun),
    .a        (valA),
    .b        (valB),
    .result   (alu_result),
    .zf       (alu_zf),
    .sf       (alu_sf),
    .of       (alu_of),
    .fn_valid (alu_fn_valid)
  );

  // The stage stalls when halted, when flushing, or when the held result is not drained
  assign in_ready = !halted && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Per-icode valE, condition and validity; invalid instructions force valE/cnd to 0
  always_comb begin
    val_e_calc = '0;
    cnd_calc   = 1'b0;
    err_calc   = 1'b0;
    case (icode)
      I_HALT, I_NOP: val_e_calc = '0;
      I_CMOVXX: begin
        val_e_calc = valA;
        cnd_calc   = cond_eval(ifun, cc);
        err_calc   = (ifun > COND_MAX);
      end
      I_IRMOVQ:         val_e_calc = valC;
      I_RMMOVQ, I_MRMOVQ: val_e_calc = valB + valC;
      I_OPQ: begin
        val_e_calc = alu_result;
        err_calc   = !alu_fn_valid;
      end
      I_JXX: begin
        cnd_calc = cond_eval(ifun, cc);
        err_calc = (ifun > COND_MAX);
      end
      I_CALL, I_PUSHQ: val_e_calc = valB - STEP;
      I_RET, I_POPQ:   val_e_calc = valB + STEP;
      default:         err_calc = 1'b1;
    endcase
    if (err_calc) begin
      val_e_calc = '0;
      cnd_calc   = 1'b0;
    end
  end

  assign cc_we = accept && (icode == I_OPQ) && !err_calc;

  // Output register: load on accept, drop on consume or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_icode <= 4'h0;
      out_valE  <= '0;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_valE  <= val_e_calc;
      out_cnd   <= cnd_calc;
      out_err   <= err_calc;
    end else if (out_ready || flush) begin
      out_valid <= 1'b0;
    end
  end

  // Condition-code register, written only by accepted valid OPq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (cc_we) begin
      cc <= {alu_zf, alu_sf, alu_of};
    end
  end

  // Sticky halt flag set when a halt is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (accept && (icode == I_HALT)) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Randomised scoreboard bench for y86_execute_stage (W=64).
module tb_y86_execute_stage;

  localparam int TW = 64;

  typedef struct {
    logic [3:0]    icode;
    logic [TW-1:0] vale;
    logic          cnd;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    icode;
  logic [3:0]    ifun;
  logic [TW-1:0] valA;
  logic [TW-1:0] valB;
  logic [TW-1:0] valC;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_icode;
  logic [TW-1:0] out_valE;
  logic          out_cnd;
  logic          out_err;
  logic [2:0]    cc;
  logic          halted;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic pushed_now = 1'b0;
  logic [2:0] cc_m = 3'b100;
  logic halted_m = 1'b0;
  logic ov_m = 1'b0;

  y86_execute_stage #(.W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_valE(out_valE), .out_cnd(out_cnd),
    .out_err(out_err), .cc(cc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: Y86 execute semantics with signed wide arithmetic
  function automatic exp_t ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                    input logic [TW-1:0] a, input logic [TW-1:0] b,
                                    input logic [TW-1:0] c, input logic [2:0] ccv,
                                    output logic [2:0] cc_new, output logic wr);
    exp_t e;
    logic signed [TW:0] wide;
    logic signed [2*TW-1:0] prod;
    logic lt, zf, sf, of, cond_ok;
    e.icode = ic; e.vale = '0; e.cnd = 1'b0; e.err = 1'b0;
    cc_new = ccv; wr = 1'b0; of = 1'b0;
    zf = ccv[2]; sf = ccv[1];
    lt = ccv[1] != ccv[0];
    cond_ok = 1'b0;
    case (fn)
      0: cond_ok = 1'b1;
      1: cond_ok = lt || zf;
      2: cond_ok = lt;
      3: cond_ok = zf;
      4: cond_ok = !zf;
      5: cond_ok = !lt;
      6: cond_ok = !lt && !zf;
      default: cond_ok = 1'b0;
    endcase
    case (ic)
      4'h0, 4'h1: e.vale = '0;
      4'h2: if (fn > 6) e.err = 1'b1; else begin e.vale = a; e.cnd = cond_ok; end
      4'h3: e.vale = c;
      4'h4, 4'h5: e.vale = b + c;
      4'h7: if (fn > 6) e.err = 1'b1; else e.cnd = cond_ok;
      4'h8, 4'hA: e.vale = b - TW'(TW / 8);
      4'h9, 4'hB: e.vale = b + TW'(TW / 8);
      4'h6: begin
        wr = 1'b1;
        case (fn)
          0: begin wide = $signed({b[TW-1], b}) + $signed({a[TW-1], a});
                   e.vale = wide[TW-1:0]; of = wide[TW] != wide[TW-1]; end
          1: begin wide = $signed({b[TW-1], b}) - $signed({a[TW-1], a});
                   e.vale = wide[TW-1:0]; of = wide[TW] != wide[TW-1]; end
          2: e.vale = b & a;
          3: e.vale = b ^ a;
`ifdef Y86_EXEC_IMUL_EN
          4: begin prod = $signed(b) * $signed(a); e.vale = prod[TW-1:0];
                   of = prod != {{TW{prod[TW-1]}}, prod[TW-1:0]}; end
`endif
          default: begin e.err = 1'b1; wr = 1'b0; end
        endcase
        if (wr) cc_new = {e.vale == '0, e.vale[TW-1], of};
      end
      default: e.err = 1'b1;
    endcase
    prod = '0;
    return e;
  endfunction

  // One stimulus cycle: drive, check handshake/state against the model, push expectations
  task automatic drive(input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [TW-1:0] c,
                       input logic fl, input logic ordy);
    exp_t e;
    logic [2:0] ccn;
    logic wr, exp_ready, acc;
    @(negedge clk);
    pushed_now = 1'b0;
    in_valid = iv; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    flush = fl; out_ready = ordy;
    #1;
    exp_ready = !halted_m && !fl && (!ov_m || ordy);
    check("in_ready", TW'(in_ready), TW'(exp_ready));
    check("cc", TW'(cc), TW'(cc_m));
    check("halted", TW'(halted), TW'(halted_m));
    acc = iv && exp_ready;
    if (acc) begin
      e = ref_exec(ic, fn, a, b, c, cc_m, ccn, wr);
      q.push_back(e);
      pushed_now = 1'b1;
      cc_m = ccn;
      if (ic == 4'h0) halted_m = 1'b1;
    end
    ov_m = acc ? 1'b1 : ((fl || ordy) ? 1'b0 : ov_m);
  endtask

  // Asynchronous reset pulse between clock edges; effect must be immediate
  task automatic reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst out_valid", TW'(out_valid), '0);
    check("rst out_icode", TW'(out_icode), '0);
    check("rst out_valE", out_valE, '0);
    check("rst out_cnd", TW'(out_cnd), '0);
    check("rst out_err", TW'(out_err), '0);
    check("rst cc", TW'(cc), TW'(3'b100));
    check("rst halted", TW'(halted), '0);
    q.delete();
    pushed_now = 1'b0;
    cc_m = 3'b100; halted_m = 1'b0; ov_m = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare the held result with the scoreboard head, pop on consume/flush
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("out_valid", TW'(out_valid), TW'((q.size() - int'(pushed_now)) > 0));
        if (out_valid && (q.size() - int'(pushed_now)) > 0) begin
          check("out_icode", TW'(out_icode), TW'(q[0].icode));
          check("out_valE", out_valE, q[0].vale);
          check("out_cnd", TW'(out_cnd), TW'(q[0].cnd));
          check("out_err", TW'(out_err), TW'(q[0].err));
          if (out_ready || flush) begin
            $display("[TB] txn icode=%h valE=%h cnd=%0d err=%0d", out_icode, out_valE, out_cnd, out_err);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [TW-1:0] rand_val();
    logic [TW-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = {1'b0, {(TW-1){1'b1}}};
      2: v = {1'b1, {(TW-1){1'b0}}};
      3: v = '1;
      4: v = TW'($urandom_range(0, 16));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0] ic, fn;
    logic [TW-1:0] a, b;
    int stuck;
    rst_n = 1'b0; in_valid = 1'b0; icode = '0; ifun = '0;
    valA = '0; valB = '0; valC = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("init out_valid", TW'(out_valid), '0);
    check("init out_valE", out_valE, '0);
    check("init cc", TW'(cc), TW'(3'b100));
    check("init halted", TW'(halted), '0);
    rst_n = 1'b1;

    // Directed scenarios
    drive(1, 4'h6, 4'h1, 64'd5, 64'd5, 0, 0, 1);                 // sub -> 0
    drive(1, 4'h7, 4'h3, 0, 0, 0, 0, 1);                         // je taken
    drive(1, 4'h7, 4'h4, 0, 0, 0, 0, 1);                         // jne not taken
    drive(1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1); // add overflow
    drive(1, 4'h2, 4'h2, 64'h55, 0, 0, 0, 1);                    // cmovl not taken
    drive(1, 4'hA, 4'h0, 0, 64'h100, 0, 0, 1);                   // pushq
    drive(1, 4'hB, 4'h0, 0, 64'hF8, 0, 0, 1);                    // popq
    drive(1, 4'h4, 4'h0, 0, 64'h10, 64'h20, 0, 1);               // rmmovq
    repeat (3) drive(1, 4'h1, 4'h0, 0, 0, 0, 0, 0);              // backpressure
    drive(1, 4'h1, 4'h0, 0, 0, 0, 0, 1);                         // release
    drive(1, 4'h6, 4'h0, 64'd3, 64'd4, 0, 0, 1);
    drive(1, 4'h6, 4'h1, 64'd1, 64'd9, 0, 1, 0);                 // flush blocks
    drive(0, 4'h0, 4'h0, 0, 0, 0, 0, 1);
    drive(1, 4'h6, 4'h4, 64'd3, 64'd3, 0, 0, 1);                 // OPq ifun 4
    drive(1, 4'hC, 4'h0, 0, 0, 0, 0, 1);                         // bad icode
    drive(1, 4'h0, 4'h0, 0, 0, 0, 0, 1);                         // halt
    repeat (2) drive(1, 4'h1, 4'h0, 0, 0, 0, 0, 1);
    reset_pulse();

    // Randomised traffic
    stuck = 0;
    for (int n = 0; n < 3000; n++) begin
      ic = 4'($urandom_range(0, 13));
      if (ic == 4'h0 && $urandom_range(0, 7) != 0) ic = 4'h1;
      if (ic == 4'h6)                 fn = 4'($urandom_range(0, 5));
      else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 7));
      else                            fn = 4'($urandom_range(0, 15));
      a = rand_val();
      b = ($urandom_range(0, 5) == 0) ? a : rand_val();
      drive($urandom_range(0, 4) != 0, ic, fn, a, b, rand_val(),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      if (halted_m) stuck++;
      if (stuck > 4) begin
        reset_pulse();
        stuck = 0;
      end
    end
    if (halted_m) reset_pulse();
    repeat (3) drive(0, 4'h1, 4'h0, 0, 0, 0, 0, 1);
    check("scoreboard drained", TW'(q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/y86_execute_stage.md
# y86_execute_stage

Parametrised, registered Y86 execute stage for the pipelined processor. It replaces the combinational sequential-design execute unit. It accepts decoded operands (icode, ifun, valA, valB, valC) over a valid/ready handshake and computes valE and the branch/cmov condition `cnd`. It owns the condition-code register and supports flush, halt latching and invalid-instruction flagging. It sits between the decode and memory stages.

## Interface
- `W`, 64: datapath width in bits; must be a multiple of 8 and at least 16.
- `STACK_STEP`, W/8: stack-pointer increment/decrement for call/ret/pushq/popq.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: an instruction is presented.
- `in_ready` out 1: the stage accepts this cycle.
- `icode`, `ifun` in 4 each: decoded opcode and function.
- `valA`, `valB`, `valC` in W each: operands, signed two's complement.
- `flush` in 1: squash the held result and the current input.
- `out_valid` out 1: the result register holds a valid instruction.
- `out_ready` in 1: the memory stage consumes the result.
- `out_icode` out 4: icode of the held result.
- `out_valE` out W: ALU result.
- `out_cnd` out 1: condition outcome.
- `out_err` out 1: the held instruction was invalid.
- `cc` out 3: {ZF, SF, OF} register.
- `halted` out 1: a halt has been accepted.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = !halted && !flush && (!out_valid || out_ready)`.
- valE by icode:
  - nop/halt (0/1): 0.
  - cmovXX (2): valA.
  - irmovq (3): valC.
  - rmmovq/mrmovq (4/5): valB+valC.
  - OPq (6): valB op valA, with ifun 0 add, 1 sub (valB−valA), 2 and, 3 xor.
  - jXX (7): 0.
  - call/pushq (8/A): valB−STACK_STEP.
  - ret/popq (9/B): valB+STACK_STEP.
- All arithmetic is modulo 2^W.
- `cnd` is evaluated from the registered CC using ifun:
  - 0 always.
  - 1 le = (SF^OF)|ZF.
  - 2 l = SF^OF.
  - 3 e = ZF.
  - 4 ne = !ZF.
  - 5 ge = !(SF^OF).
  - 6 g = !(SF^OF)&!ZF.
- `cnd` is meaningful for icode 2 and 7 only; it is 0 for all other icodes.
- CC update:
  - Updated only on acceptance of a valid OPq.
  - ZF = (result == 0); SF = result[W−1].
  - add: OF = sign(a)==sign(b) && sign(res)!=sign(a).
  - sub: OF = sign(valB)!=sign(valA) && sign(res)!=sign(valB).
  - and/xor: OF = 0.
- Invalid input: icode > B, OPq ifun > 3 (without the multiply option), or cmov/jXX ifun > 6.
  - It is still accepted, with `out_err` = 1 and `out_valE` = 0.
  - It does not update CC.
- Halt: accepting icode 0 sets `halted` sticky until reset. The halt itself is passed through to the output.
- Flush:
  - Clears `out_valid` at the next edge.
  - Blocks acceptance that cycle.
  - Does not alter CC or `halted`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the out_* ports after edge N.
- Throughput is 1 instruction per cycle when `out_ready` is held high.
- Back-to-back dependency: an OPq accepted at edge N updates CC at N. A cmov/jXX accepted at edge N+1 sees the new CC.
- Backpressure: while `out_valid && !out_ready`, all out_* ports hold stable and `in_ready` = 0.
- Reset values: `out_valid` 0, `out_icode` 0, `out_valE` 0, `out_cnd` 0, `out_err` 0, `cc` = {1,0,0}, `halted` 0.
- A reset mid-transfer discards the held result immediately and asynchronously.
- If flush and `out_ready` are both high, the result is counted as consumed and not duplicated. `out_valid` is 0 after the edge.

## Configuration
- `Y86_EXEC_IMUL_EN` defined:
  - OPq ifun 4 = signed multiply, valE = low W bits of valB*valA.
  - OF = 1 if the full 2W-bit product is not the sign-extension of the low W bits. ZF and SF are computed as for other OPq.
  - Remains single-cycle.
- Not defined: OPq ifun 4 is invalid; it sets `out_err` and does not update CC.

## Structure
- Package `y86_pkg`: icode constants (I_HALT…I_POPQ), ALU function and condition encodings, CC bit indices, CC reset value.
- Sub-module `y86_alu`: combinational operation and flag computation (add/sub/and/xor/optional mul), parametrised by `W`.
- Condition evaluation, handshake, CC register and output register live in the top.

## Test plan
- W=64, CC=reset. OPq sub with valB=5, valA=5 -> valE=0, CC={1,0,0}. Next jXX ifun 3 gives cnd=1; ifun 4 gives cnd=0.
- OPq add with valB=0x7FFF_FFFF_FFFF_FFFF, valA=1 -> valE=0x8000_0000_0000_0000, CC={0,1,1}. Following cmovl (ifun 2) gives cnd=0.
- pushq with valB=0x100 -> valE=0xF8. popq with valB=0xF8 -> valE=0x100. W=32 build with the same inputs -> step is 4 (0xFC and 0x100).
- Hold out_ready=0 for 3 cycles after an accepted rmmovq (valB=0x10, valC=0x20) -> valE=0x30 held stable, in_ready=0. Release -> the next instruction is accepted the same cycle.
- Accept halt, then present nop -> halted=1, in_ready stays 0. Pulse rst_n low mid-cycle -> outputs and CC return to reset values immediately.
- Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, CC unchanged. OPq ifun 4 without the macro -> out_err=1, valE=0, CC unchanged.
